// File: rtl/display_sequencer.sv
// -----------------------------------------------------------------------------
// display_sequencer
//
// VGA-style timing generator plus a small screen-selection sequencer.
//
// A clock divider produces a one-cycle pixel_tick every CLK_DIV system clocks.
// Horizontal and vertical counters advance on each pixel_tick. Sync pulses are
// registered from the same next-state counter values, so hsync and vsync never
// skew relative to each other or to the counters.
//
// A four-state FSM (IDLE, PEND, SHOW, LOCK) accepts screen requests through a
// valid/ready handshake. Screen changes only ever take effect on a frame_end
// edge (pixel_tick with H and V both at their last value), so the pixel-source
// mux never switches mid-frame. Hit/miss screens are held for HOLD_FRAMES
// frames and then revert to the board; the win screen locks until reset.
//
// Parameters
//   CLK_DIV      system clocks per pixel tick (>= 1)
//   HOLD_FRAMES  frames a hit or miss screen is shown (0 behaves as 1)
//   H_TOTAL      pixels per line, including blanking (default 800)
//   V_TOTAL      lines per frame, including blanking (default 525)
//   H_SYNC       pixels of active-low hsync at the start of a line (default 96)
//   V_SYNC       lines of active-low vsync at the start of a frame (default 2)
//
// Ports
//   clk              in   system clock, rising-edge active
//   rst_n            in   asynchronous active-low reset
//   req_valid        in   screen request valid
//   req_code[1:0]    in   00 board, 01 hit, 10 miss, 11 win
//   req_ready        out  request can be accepted (only in IDLE)
//   pixel_tick       out  one-clock pulse every CLK_DIV clocks
//   H_Counter_Value  out  horizontal pixel count, 0..H_TOTAL-1
//   V_Counter_Value  out  vertical line count, 0..V_TOTAL-1
//   hsync            out  active-low horizontal sync
//   vsync            out  active-low vertical sync
//   sel[1:0]         out  screen select for the pixel-source mux
//   busy             out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module display_sequencer #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned HOLD_FRAMES = 120,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_SYNC      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_code,
  output logic        req_ready,
  output logic        pixel_tick,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  sel,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int unsigned DIV_W = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 32'd1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 32'd1);
  localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);

  // A hold of zero frames is treated as one so SHOW always lasts a full frame
  // and the counter can never start at zero and wrap.
  localparam logic [15:0] HOLD_LOAD =
    16'((HOLD_FRAMES == 32'd0) ? 32'd1 : HOLD_FRAMES);

  localparam logic [1:0] CODE_BOARD = 2'b00;
  localparam logic [1:0] CODE_WIN   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_SHOW = 2'b10,
    ST_LOCK = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Timing generator state
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_end_s;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] frames_q, frames_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        accept_s;

  // Next-state logic for divider, pixel counters and sync pulses.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? DIV_ZERO : (div_q + DIV_ONE);
    // tick_q is the registered image of "divider == CLK_DIV-1".
    tick_d = (div_d == DIV_LAST);

    h_d = h_q;
    v_d = v_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = 16'd0;
        if (v_q == V_LAST) begin
          v_d = 16'd0;
        end else begin
          v_d = v_q + 16'd1;
        end
      end else begin
        h_d = h_q + 16'd1;
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end

    // Sync is derived from the next counter values so that after the clock
    // edge hsync/vsync describe exactly the H/V values being presented.
    hsync_d = (h_d >= H_SYNC_END);
    vsync_d = (v_d >= V_SYNC_END);
  end

  // Timing registers: free-running in every FSM state, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= DIV_ZERO;
      tick_q  <= 1'b0;
      h_q     <= 16'd0;
      v_q     <= 16'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  // The last pixel tick of a frame; all screen changes happen on this edge.
  assign frame_end_s = tick_q && (h_q == H_LAST) && (v_q == V_LAST);

  // Handshake completes on the edge where both valid and ready are high.
  assign accept_s = req_valid && ready_q;

  // Sequencer next-state logic.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    sel_d    = sel_q;
    frames_d = frames_q;
    ready_d  = ready_q;

    case (state_q)
      ST_IDLE: begin
        sel_d    = CODE_BOARD;
        frames_d = 16'd0;
        // ready rises on the first edge after reset release.
        ready_d  = 1'b1;
        if (accept_s && (req_code != CODE_BOARD)) begin
          // Entering PEND from here means a frame_end on this same edge is
          // not used; the switch waits for the next frame boundary.
          state_d = ST_PEND;
          code_d  = req_code;
          ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PEND: begin
        ready_d = 1'b0;
        if (frame_end_s) begin
          sel_d    = code_q;
          frames_d = HOLD_LOAD;
          if (code_q == CODE_WIN) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_SHOW;
          end
        end else begin
          state_d = ST_PEND;
        end
      end

      ST_SHOW: begin
        ready_d = 1'b0;
        if (frame_end_s) begin
          // "<= 1" rather than "== 1" keeps the counter from ever wrapping.
          if (frames_q <= 16'd1) begin
            state_d  = ST_IDLE;
            sel_d    = CODE_BOARD;
            frames_d = 16'd0;
            ready_d  = 1'b1;
          end else begin
            frames_d = frames_q - 16'd1;
          end
        end else begin
          state_d = ST_SHOW;
        end
      end

      ST_LOCK: begin
        state_d = ST_LOCK;
        sel_d   = CODE_WIN;
        ready_d = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        code_d   = CODE_BOARD;
        sel_d    = CODE_BOARD;
        frames_d = 16'd0;
        ready_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer registers, including the registered handshake/select outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_q   <= CODE_BOARD;
      sel_q    <= CODE_BOARD;
      frames_q <= 16'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      sel_q    <= sel_d;
      frames_q <= frames_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven directly from registers)
  // ---------------------------------------------------------------------------
  assign pixel_tick      = tick_q;
  assign H_Counter_Value = h_q;
  assign V_Counter_Value = v_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign sel             = sel_q;
  assign req_ready       = ready_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_display_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for display_sequencer.
//
// dut1 uses a shrunken raster (CLK_DIV=2, 20x10, HOLD_FRAMES=3) so that many
// frames and sequencer scenarios fit in a short run. dut2 uses the default
// 800x525 / CLK_DIV=4 geometry with requests tied off and free-runs.
//
// The reference model describes behaviour in terms of elapsed clock edges
// since reset release: timing outputs follow from integer division, and a
// request is modelled as an "engagement" that starts at its acceptance edge
// and whose screen is visible from the next frame index onward.
// -----------------------------------------------------------------------------
module tb_display_sequencer;

  localparam int D1 = 2, HT1 = 20, VT1 = 10, HS1 = 4, VS1 = 2, HOLD1 = 3;
  localparam int D2 = 4, HT2 = 800, VT2 = 525, HS2 = 96, VS2 = 2;
  localparam int FRAME1 = D1 * HT1 * VT1;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_code  = 2'b00;

  logic        r1, t1, hs1, vs1, b1;
  logic [15:0] h1, v1;
  logic [1:0]  sel1;
  logic        r2, t2, hs2, vs2, b2;
  logic [15:0] h2, v2;
  logic [1:0]  sel2;

  display_sequencer #(
    .CLK_DIV(D1), .HOLD_FRAMES(HOLD1), .H_TOTAL(HT1), .V_TOTAL(VT1),
    .H_SYNC(HS1), .V_SYNC(VS1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
    .req_ready(r1), .pixel_tick(t1), .H_Counter_Value(h1),
    .V_Counter_Value(v1), .hsync(hs1), .vsync(vs1), .sel(sel1), .busy(b1)
  );

  display_sequencer dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(1'b0), .req_code(2'b00),
    .req_ready(r2), .pixel_tick(t2), .H_Counter_Value(h2),
    .V_Counter_Value(v2), .hsync(hs2), .vsync(vs2), .sel(sel2), .busy(b2)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release and the current engagement.
  int         n      = 0;
  bit         act    = 1'b0;
  int         fa     = 0;
  logic [1:0] code_m = 2'b00;

  function automatic int frame_of(int cyc, int d, int ht, int vt);
    return (cyc / d) / (ht * vt);
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic expect_timing(input string tag, input int cyc, input int d,
                               input int ht, input int vt, input int hsw,
                               input int vsw, input logic tk,
                               input logic [15:0] h, input logic [15:0] v,
                               input logic hs, input logic vs);
    int t;
    int eh;
    int ev;
    t  = cyc / d;
    eh = t % ht;
    ev = (t / ht) % vt;
    chk({tag, ".pixel_tick"}, 32'(tk), (cyc > 0 && (cyc % d) == d - 1) ? 32'd1 : 32'd0);
    chk({tag, ".H"}, 32'(h), 32'(eh));
    chk({tag, ".V"}, 32'(v), 32'(ev));
    chk({tag, ".hsync"}, 32'(hs), (cyc == 0 || eh >= hsw) ? 32'd1 : 32'd0);
    chk({tag, ".vsync"}, 32'(vs), (cyc == 0 || ev >= vsw) ? 32'd1 : 32'd0);
  endtask

  task automatic compare_all();
    logic [1:0] exp_sel;
    expect_timing("dut1", n, D1, HT1, VT1, HS1, VS1, t1, h1, v1, hs1, vs1);
    expect_timing("dut2", n, D2, HT2, VT2, HS2, VS2, t2, h2, v2, hs2, vs2);
    exp_sel = (act && frame_of(n, D1, HT1, VT1) >= fa + 1) ? code_m : 2'b00;
    chk("dut1.sel", 32'(sel1), 32'(exp_sel));
    chk("dut1.req_ready", 32'(r1), (n >= 1 && !act) ? 32'd1 : 32'd0);
    chk("dut1.busy", 32'(b1), act ? 32'd1 : 32'd0);
    chk("dut2.sel", 32'(sel2), 32'd0);
    chk("dut2.req_ready", 32'(r2), (n >= 1) ? 32'd1 : 32'd0);
    chk("dut2.busy", 32'(b2), 32'd0);
  endtask

  // Reference model update at every clock edge / reset assertion.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n   = 0;
      act = 1'b0;
    end else begin
      if (n >= 1 && !act && req_valid && req_code != 2'b00) begin
        act    = 1'b1;
        code_m = req_code;
        fa     = frame_of(n + 1, D1, HT1, VT1);
      end
      n = n + 1;
      if (act && code_m != 2'b11 && frame_of(n, D1, HT1, VT1) >= fa + 1 + HOLD1)
        act = 1'b0;
    end
  end

  // Compare process: outputs checked against the model every falling edge.
  initial forever begin
    @(negedge clk);
    compare_all();
  end

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_n(input int target);
    while (n < target) @(negedge clk);
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (r1 !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("wait_ready", 32'(r1), 32'd1);
  endtask

  task automatic pulse_req(input logic [1:0] c);
    req_valid = 1'b1;
    req_code  = c;
    @(negedge clk);
    req_valid = 1'b0;
    req_code  = 2'b00;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".H"}, 32'(h1), 32'd0);
    chk({tag, ".V"}, 32'(v1), 32'd0);
    chk({tag, ".tick"}, 32'(t1), 32'd0);
    chk({tag, ".hsync"}, 32'(hs1), 32'd1);
    chk({tag, ".vsync"}, 32'(vs1), 32'd1);
    chk({tag, ".sel"}, 32'(sel1), 32'd0);
    chk({tag, ".busy"}, 32'(b1), 32'd0);
    chk({tag, ".ready"}, 32'(r1), 32'd0);
  endtask

  initial begin
    int cnt;
    int base;
    int w;

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    chk("rst.dut2_hsync", 32'(hs2), 32'd1);
    rst_n = 1'b1;

    // Hand-computed timing pins.
    @(negedge clk);
    chk("lit.ready_first_edge", 32'(r1), 32'd1);
    chk("lit.dut1_tick_n1", 32'(t1), 32'd1);
    chk("lit.dut2_tick_n1", 32'(t2), 32'd0);
    wait_n(3);   chk("lit.dut2_tick_n3", 32'(t2), 32'd1);
    wait_n(4);   chk("lit.dut2_H_n4", 32'(h2), 32'd1);
                 chk("lit.dut1_H_n4", 32'(h1), 32'd2);
    wait_n(383); chk("lit.dut2_hsync_low_end", 32'(hs2), 32'd0);
    wait_n(384); chk("lit.dut2_hsync_high", 32'(hs2), 32'd1);
    wait_n(399); chk("lit.dut1_last_H", 32'(h1), 32'd19);
                 chk("lit.dut1_last_V", 32'(v1), 32'd9);
    wait_n(400); chk("lit.dut1_wrap_V", 32'(v1), 32'd0);
    wait_n(3199); chk("lit.dut2_H799", 32'(h2), 32'd799);
    wait_n(3200); chk("lit.dut2_Hwrap", 32'(h2), 32'd0);
                  chk("lit.dut2_Vinc", 32'(v2), 32'd1);

    // Hit requested mid-frame: shown for exactly HOLD1 frames.
    wait_ready();
    while (n % FRAME1 != 150) @(negedge clk);
    pulse_req(2'b01);
    chk("hit.ready_drop", 32'(r1), 32'd0);
    chk("hit.sel_pending", 32'(sel1), 32'd0);
    cnt = 0;
    repeat (5 * FRAME1) begin
      if (sel1 == 2'b01) cnt++;
      @(negedge clk);
    end
    chk("hit.cycles_shown", 32'(cnt), 32'(HOLD1 * FRAME1));
    chk("hit.ready_back", 32'(r1), 32'd1);

    // Miss accepted on the very frame_end edge waits a full frame.
    wait_ready();
    while (n % FRAME1 != FRAME1 - 1) @(negedge clk);
    base = n + 1;
    pulse_req(2'b10);
    wait_n(base + FRAME1 - 1); chk("miss.still_pending", 32'(sel1), 32'd0);
    wait_n(base + FRAME1);     chk("miss.shown", 32'(sel1), 32'd2);

    // Hit held valid throughout SHOW: no extension, re-accepted afterwards.
    wait_ready();
    req_valid = 1'b1;
    req_code  = 2'b01;
    wait_cycles(5 * FRAME1);
    req_valid = 1'b0;
    req_code  = 2'b00;

    // Random board/hit/miss requests.
    wait_ready();
    repeat (12 * FRAME1) begin
      req_valid = ($urandom_range(0, 15) == 0);
      req_code  = 2'($urandom_range(0, 2));
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_code  = 2'b00;

    // Asynchronous reset during SHOW.
    wait_ready();
    pulse_req(2'b01);
    w = 0;
    while (sel1 != 2'b01 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("show.reached", 32'(sel1), 32'd1);
    wait_cycles(77);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_n(2);
    chk("async_rst.restart_H", 32'(h1), 32'd1);

    // Win locks; later hit requests are ignored until reset.
    wait_ready();
    pulse_req(2'b11);
    repeat (4) begin
      wait_cycles(FRAME1 - 1);
      pulse_req(2'b01);
    end
    chk("win.sel", 32'(sel1), 32'd3);
    chk("win.ready", 32'(r1), 32'd0);
    chk("win.busy", 32'(b1), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 chk("win_rst.sel", 32'(sel1), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_n(1);
    chk("win_rst.ready", 32'(r1), 32'd1);
    chk("win_rst.sel_after", 32'(sel1), 32'd0);
    wait_cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
